// File: rtl/dmem_pkg.sv
// Shared types for the load/store data memory.
//   size_e  : access width encoding carried on req_size
//   state_e : controller FSM states
//   WAIT_W  : width of the wait-state counter (WAIT_CYCLES is 0..15)
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  localparam int WAIT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Purely combinational byte-lane steering shared by the store and load paths.
// Ports:
//   size_i        access size
//   lane_i        byte offset within the word (addr[1:0])
//   ld_unsigned_i 1 = zero-extend loads, 0 = sign-extend
//   wdata_i       right-aligned store data
//   rword_i       raw word read from the array
//   be_o          byte-lane write mask
//   wdata_o       store data replicated into every candidate lane
//   rdata_o       extracted and extended load data
//   misalign_o    half on an odd lane, or word on a non-zero lane
module dmem_lane_align
  import dmem_pkg::*;
(
  input  size_e       size_i,
  input  logic [1:0]  lane_i,
  input  logic        ld_unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = 32'h0;
    rdata_o    = 32'h0;
    misalign_o = 1'b0;
    rbyte      = rword_i[{lane_i, 3'b000} +: 8];
    rhalf      = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    case (size_i)
      SZ_B: begin
        be_o    = 4'b0001 << lane_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~ld_unsigned_i & rbyte[7]}}, rbyte};
      end
      SZ_H: begin
        misalign_o = lane_i[0];
        be_o       = lane_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{~ld_unsigned_i & rhalf[15]}}, rhalf};
      end
      SZ_W: begin
        misalign_o = (lane_i != 2'b00);
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        rdata_o    = rword_i;
      end
      default: begin
        // Reserved size: no lanes selected; the top level flags the error.
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Data memory with a load/store front end, one transaction outstanding.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_we, req_size, req_unsigned, req_addr, req_wdata   request fields
//   rsp_valid/rsp_ready   response handshake (valid only in RESP)
//   rsp_rdata     extended load data, 0 for stores and errors
//   rsp_err       misaligned, out of range or reserved size
module dmem_lsu_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;

  logic        we_q, uns_q;
  size_e       size_q;
  logic [31:0] addr_q, wdata_q;

  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, access_done;
  logic [IDX_W-1:0] idx;
  logic             range_err, misalign, acc_err, do_write;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, rword, rdata_ext;

  assign accept      = (state_q == IDLE) && req_valid;
  assign access_done = (state_q == ACCESS) && (cnt_q == '0);

  assign idx       = addr_q[IDX_W+1:2];
  assign range_err = |addr_q[31:IDX_W+2];
  assign acc_err   = misalign | range_err | (size_q == SZ_RSV);
  // A reset arriving on the commit edge drops the store.
  assign do_write  = access_done && we_q && !acc_err && rst_n;
  assign rword     = mem[idx];

  dmem_lane_align u_align (
    .size_i        (size_q),
    .lane_i        (addr_q[1:0]),
    .ld_unsigned_i (uns_q),
    .wdata_i       (wdata_q),
    .rword_i       (rword),
    .be_o          (be),
    .wdata_o       (wdata_rep),
    .rdata_o       (rdata_ext),
    .misalign_o    (misalign)
  );

  // State register and wait counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = ACCESS;
          cnt_d   = WAIT_W'(WAIT_CYCLES);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs depend on state only, so they can never overlap.
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
  end

  // Request latches: loaded only on acceptance, so req_* is ignored elsewhere.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= req_we;
      size_q  <= size_e'(req_size);
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Response registers: written once at ACCESS exit, held through RESP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else if (access_done) begin
      rsp_err_q   <= acc_err;
      rsp_rdata_q <= (acc_err || we_q) ? 32'h0 : rdata_ext;
    end
  end

  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  // NOTE: the array has no reset; clearing a RAM needs a per-word sequencer
  // and prevents block-RAM inference. Contents are undefined until written.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wdata_rep[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
module tb_dmem_lsu_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        req_we       [2];
  logic [1:0]  req_size     [2];
  logic        req_unsigned [2];
  logic [31:0] req_addr     [2];
  logic [31:0] req_wdata    [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] rsp_rdata    [2];
  logic        rsp_err      [2];

  int checks = 0;
  int errors = 0;

  // Behavioural byte-addressed model of the in-range space of instance 0.
  logic [7:0] model_mem [1024];

  // Instance 0: two wait states. Instance 1: zero wait states.
  dmem_lsu_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  dmem_lsu_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
           (sz == 2'd2 && a[1:0] != 2'b00) || (a >= 32'd1024);
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                         input logic [31:0] a);
    int     n = 1 << sz;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(model_mem[a + i]) << (8 * i);
    if (!uns && v[8*n-1]) v -= (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) model_mem[a + i] = wd[8*i +: 8];
  endtask

  // One full request/response on instance d; returns data, error and the
  // number of edges from acceptance to the first visible rsp_valid.
  task automatic txn(input int d, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    check($sformatf("ready_before_req d%0d", d), 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_we[d] = we; req_size[d] = sz;
    req_unsigned[d] = uns; req_addr[d] = a; req_wdata[d] = wd;
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 0;
    while (rsp_valid[d] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (rsp_valid[d] !== 1'b1) check("rsp_timeout", 32'(rsp_valid[d]), 32'd1);
    rd = rsp_rdata[d];
    er = rsp_err[d];
    check($sformatf("ready_low_in_resp d%0d", d), 32'(req_ready[d]), 32'd0);
    @(negedge clk);
    rsp_ready[d] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[d] = 1'b0;
  endtask

  task automatic run(input string name, input int d, input logic we, input logic [1:0] sz,
                     input logic uns, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    txn(d, we, sz, uns, a, wd, rd, er, lat);
    check({name, "_rdata"}, rd, exp_rd);
    check({name, "_err"}, 32'(er), 32'(exp_er));
    check({name, "_latency"}, 32'(lat), 32'(exp_lat));
    if (d == 0 && we && !exp_er) m_store(sz, a, wd);
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  initial begin
    logic [31:0] hold_rd;
    int          waited;

    // Directed vectors: {we, size, unsigned, addr, wdata, exp_rdata, exp_err}
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'hAAAAAA80, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h00000080, 1'b0};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0};
    vecs[6]  = '{1'b0, 2'd1, 1'b1, 32'h10,  32'h0,        32'h0000BEEF, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 1'b0, 32'h11,  32'h0,        32'h0,        1'b1};
    vecs[8]  = '{1'b1, 2'd2, 1'b0, 32'h16,  32'h11111111, 32'h0,        1'b1};
    vecs[9]  = '{1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        32'hC0DE0005, 1'b0};
    vecs[10] = '{1'b0, 2'd3, 1'b0, 32'h18,  32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b0, 2'd2, 1'b0, 32'h400, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 2'd1, 1'b0, 32'h12,  32'h0,        32'hFFFF80AD, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 1'b0, 32'h3FF, 32'h0000005A, 32'h0,        1'b0};
    vecs[14] = '{1'b0, 2'd0, 1'b1, 32'h3FF, 32'h0,        32'h0000005A, 1'b0};
    vecs[15] = '{1'b1, 2'd0, 1'b0, 32'h400, 32'h000000FF, 32'h0,        1'b1};

    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_we[d] = 1'b0; req_size[d] = 2'd0;
      req_unsigned[d] = 1'b0; req_addr[d] = 32'h0; req_wdata[d] = 32'h0;
      rsp_ready[d] = 1'b0;
    end

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_req_ready", 32'(req_ready[0]), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("reset_rsp_rdata", rsp_rdata[0], 32'h0);
    check("reset_rsp_err",   32'(rsp_err[0]), 32'd0);

    // Give words 0..15 known contents.
    for (int w = 0; w < 16; w++)
      run($sformatf("init_w%0d", w), 0, 1'b1, 2'd2, 1'b0, 32'(4 * w),
          32'hC0DE0000 | 32'(w), 32'h0, 1'b0, 3);

    // Directed table.
    for (int i = 0; i < 16; i++)
      run($sformatf("vec%0d", i), 0, vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr,
          vecs[i].wd, vecs[i].exp_rd, vecs[i].exp_err, 3);

    // Response back-pressure: outputs hold, new requests are ignored.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_size[0] = 2'd2; req_addr[0] = 32'h10;
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    waited = 0;
    while (rsp_valid[0] !== 1'b1 && waited < 40) begin @(posedge clk); #1; waited++; end
    check("hold_first_valid", 32'(rsp_valid[0]), 32'd1);
    hold_rd = rsp_rdata[0];
    check("hold_rdata_initial", hold_rd, 32'h80ADBEEF);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_wdata[0] = 32'h0BADF00D;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("hold%0d_valid", c), 32'(rsp_valid[0]), 32'd1);
      check($sformatf("hold%0d_rdata", c), rsp_rdata[0], 32'h80ADBEEF);
      check($sformatf("hold%0d_err", c), 32'(rsp_err[0]), 32'd0);
      check($sformatf("hold%0d_ready", c), 32'(req_ready[0]), 32'd0);
    end
    req_valid[0] = 1'b0; req_we[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[0] = 1'b0;
    check("release_req_ready", 32'(req_ready[0]), 32'd1);
    check("release_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    run("after_hold_lw", 0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, m_load(2'd2, 1'b0, 32'h10), 1'b0, 3);

    // Reset during ACCESS drops an uncommitted store.
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_size[0] = 2'd2;
    req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678;
    @(posedge clk);
    #1 req_valid[0] = 1'b0; req_we[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
    check("midrst_req_ready", 32'(req_ready[0]), 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_late_rsp", 32'(rsp_valid[0]), 32'd0);
    run("midrst_lw", 0, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hC0DE0008, 1'b0, 3);

    // Zero wait states: response one edge after acceptance.
    run("w0_sw", 1, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1);
    run("w0_lw", 1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1);
    run("w0_lb", 1, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFFFFBE, 1'b0, 1);

    // Randomized traffic against the byte model.
    for (int n = 0; n < 150; n++) begin
      logic        we, uns, exp_er;
      logic [1:0]  sz;
      logic [31:0] a, wd, exp_rd;
      int          sel;
      we  = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 15);
      sz  = (sel == 0) ? 2'd3 : 2'(sel % 3);
      a   = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h400) : 32'($urandom_range(0, 63));
      wd  = $urandom;
      exp_er = m_err(sz, a);
      exp_rd = (exp_er || we) ? 32'h0 : m_load(sz, uns, a);
      run($sformatf("rnd%0d", n), 0, we, sz, uns, a, wd, exp_rd, exp_er, 3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
